// File: rtl/riscv_pkg.sv
// Shared definitions for the retire-side monitor:
// halt-pair default encodings and the halt FSM state type.
package riscv_pkg;

  localparam logic [31:0] HALT_INST0_DEF = 32'h00c00093;
  localparam logic [31:0] HALT_INST1_DEF = 32'h00008067;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } halt_st_e;

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-pair detector FSM. In: CLK, RSTn, valid, inst.
// Out: halted (state is HALTED), halt_now (this edge enters HALTED).
module riscv_halt_detect
  import riscv_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
  parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        valid,
  input  logic [31:0] inst,
  output logic        halted,
  output logic        halt_now
);

  halt_st_e st;
  halt_st_e st_nxt;

  logic is_i0;
  logic is_i1;

  assign is_i0 = (inst == HALT_INST0);
  assign is_i1 = (inst == HALT_INST1);

  always_comb begin
    st_nxt = st;
    if (valid) begin
      unique case (st)
        RUN: begin
          if (is_i0) st_nxt = ARMED;
        end
        ARMED: begin
          unique case (1'b1)
            is_i1:   st_nxt = HALTED;
            is_i0:   st_nxt = ARMED;
            default: st_nxt = RUN;
          endcase
        end
        HALTED:  st_nxt = HALTED;
        default: st_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) st <= RUN;
    else       st <= st_nxt;
  end

  assign halted   = (st == HALTED);
  assign halt_now = valid && (st == ARMED) && is_i1;

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire-side observation producer: retired count, last result,
// sticky HALT and a saturating cycle counter frozen at halt.
module riscv_retire_monitor
  import riscv_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
  parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RETIRE_VALID,
  input  logic [31:0]      RETIRE_INST,
  input  logic [31:0]      RETIRE_RESULT,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [31:0]      OUTPUT_PORT,
  output logic             HALT,
  output logic [CNT_W-1:0] CYCLE
);

  logic halted;
  logic halt_now;

  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cyc_q;
  logic [31:0]      out_q;
  logic             halt_q;

  riscv_halt_detect #(
    .HALT_INST0 (HALT_INST0),
    .HALT_INST1 (HALT_INST1)
  ) u_halt (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .valid    (RETIRE_VALID),
    .inst     (RETIRE_INST),
    .halted   (halted),
    .halt_now (halt_now)
  );

  // The halting retire still counts: halted is
  // only true from the edge after entry onward.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      num_q <= '0;
      out_q <= '0;
    end else if (!halted && RETIRE_VALID) begin
      if (num_q != '1) num_q <= num_q + CNT_W'(1);
      out_q <= RETIRE_RESULT;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cyc_q <= '0;
    end else if (!halted && cyc_q != '1) begin
      cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) halt_q <= 1'b0;
    else       halt_q <= halt_q | halt_now;
  end

  assign NUM_INST    = num_q;
  assign OUTPUT_PORT = out_q;
  assign HALT        = halt_q;
  assign CYCLE       = cyc_q;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Directed scoreboard bench for riscv_retire_monitor,
// plus a 4-bit-counter instance for saturation.
module tb_riscv_retire_monitor;

  localparam logic [31:0] I0  = 32'h00c00093;
  localparam logic [31:0] I1  = 32'h00008067;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK;
  logic        RSTn;
  logic        rv;
  logic [31:0] ri;
  logic [31:0] rr;

  logic [31:0] num;
  logic [31:0] outp;
  logic        halt;
  logic [31:0] cyc;

  logic [3:0]  num4;
  logic [31:0] outp4;
  logic        halt4;
  logic [3:0]  cyc4;

  riscv_retire_monitor dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .RETIRE_VALID  (rv),
    .RETIRE_INST   (ri),
    .RETIRE_RESULT (rr),
    .NUM_INST      (num),
    .OUTPUT_PORT   (outp),
    .HALT          (halt),
    .CYCLE         (cyc)
  );

  riscv_retire_monitor #(.CNT_W(4)) dut4 (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .RETIRE_VALID  (rv),
    .RETIRE_INST   (ri),
    .RETIRE_RESULT (rr),
    .NUM_INST      (num4),
    .OUTPUT_PORT   (outp4),
    .HALT          (halt4),
    .CYCLE         (cyc4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] n;
    logic [31:0] o;
    logic        h;
    logic [31:0] c;
    logic [3:0]  n4;
    logic [3:0]  c4;
    string       tag;
  } exp_t;

  exp_t q[$];

  int vec  = 0;
  int miss = 0;

  // reference model state
  logic [31:0] m_n;
  logic [31:0] m_o;
  logic        m_h;
  logic [31:0] m_c;
  logic [3:0]  m_n4;
  logic [3:0]  m_c4;
  int          m_st;

  task automatic cmp(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.n = m_n; e.o = m_o; e.h = m_h; e.c = m_c;
    e.n4 = m_n4; e.c4 = m_c4; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      vec++;
      miss++;
      $error("FAIL scoreboard_empty got 0 exp 1");
      return;
    end
    e = q.pop_front();
    cmp({e.tag, ".num"},   num,           e.n);
    cmp({e.tag, ".out"},   outp,          e.o);
    cmp({e.tag, ".halt"},  {31'b0, halt}, {31'b0, e.h});
    cmp({e.tag, ".cycle"}, cyc,           e.c);
    cmp({e.tag, ".num4"},  {28'b0, num4}, {28'b0, e.n4});
    cmp({e.tag, ".cyc4"},  {28'b0, cyc4}, {28'b0, e.c4});
    cmp({e.tag, ".halt4"}, {31'b0, halt4}, {31'b0, e.h});
    cmp({e.tag, ".out4"},  outp4,         e.o);
  endtask

  task automatic model_reset();
    m_n = '0; m_o = '0; m_h = 1'b0; m_c = '0;
    m_n4 = '0; m_c4 = '0; m_st = 0;
  endtask

  // one clock edge with the given retire inputs
  task automatic step(input logic v, input logic [31:0] inst,
                      input logic [31:0] res, input string tag);
    rv = v; ri = inst; rr = res;
    if (!m_h) begin
      m_c = m_c + 1;
      if (m_c4 != 4'hf) m_c4 = m_c4 + 4'd1;
      if (v) begin
        m_n = m_n + 1;
        if (m_n4 != 4'hf) m_n4 = m_n4 + 4'd1;
        m_o = res;
        case (m_st)
          0: if (inst == I0) m_st = 1;
          1: begin
            if (inst == I1) begin
              m_st = 2;
              m_h  = 1'b1;
            end else if (inst != I0) begin
              m_st = 0;
            end
          end
          default: ;
        endcase
      end
    end
    push(tag);
    @(posedge CLK);
    #1;
    check();
  endtask

  // async assert mid-cycle, check before any edge, release at negedge
  task automatic do_reset(input string tag);
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    push(tag);
    check();
    @(negedge CLK);
    RSTn = 1'b1;
    rv = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0;
    rv = 1'b0; ri = '0; rr = '0;
    model_reset();
    #3;
    push("por");
    check();
    @(negedge CLK);
    RSTn = 1'b1;

    step(1, NOP, 32'h0f00, "pair1");
    step(1, NOP, 32'h18,   "pair2");
    step(1, NOP, 32'h1d,   "pair3");
    step(1, NOP, 32'h1e,   "pair4");

    do_reset("rst_bub");
    step(1, NOP, 32'hA, "bub_a");
    step(0, NOP, 32'h77, "bub_i0");
    step(0, NOP, 32'h77, "bub_i1");
    step(0, NOP, 32'h77, "bub_i2");
    step(1, NOP, 32'hB, "bub_b");
    cmp("bub_num_final", num, 32'd2);

    do_reset("rst_hb");
    step(1, I0, 32'hc, "hb_i0");
    step(0, NOP, 32'h0, "hb_gap");
    step(1, I1, 32'h1, "hb_i1");
    cmp("hb_halt_num", num, 32'd2);
    for (int i = 0; i < 3; i++) step(1, NOP, 32'h55, "hb_post");
    step(1, I0, 32'h55, "hb_post_i0");

    do_reset("rst_brk");
    step(1, I0,  32'hc, "brk_i0");
    step(1, NOP, 32'h2, "brk_nop");
    step(1, I1,  32'h3, "brk_i1");
    cmp("brk_halt", {31'b0, halt}, 32'd0);

    do_reset("rst_rep");
    step(1, I0, 32'hc, "rep_a");
    step(1, I0, 32'hc, "rep_b");
    step(1, I1, 32'h9, "rep_c");
    cmp("rep_halt", {31'b0, halt}, 32'd1);

    do_reset("rst_long");
    for (int i = 0; i < 32'h133e; i++) step(1, NOP, i, "long");
    step(1, I0, 32'hc, "long_i0");
    step(1, I1, 32'h1, "long_i1");
    cmp("long_num", num, 32'h1340);
    step(0, NOP, 32'h0, "long_hold");
    do_reset("rst_async");
    step(1, NOP, 32'h42, "restart");
    cmp("restart_num", num, 32'd1);
    cmp("restart_cyc", cyc, 32'd1);

    if (q.size() != 0) begin
      vec++;
      miss++;
      $error("FAIL scoreboard_left got %0d exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
